// File: rtl/asi_r.sv
// AXI slave read interface: accepts AR bursts, issues per-beat reads to a fixed-latency
// user memory port and returns the data on the R channel through an internal FIFO.
module asi_r #(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 40,
    parameter int AXI_IW     = 8,
    parameter int AXI_LW     = 8,
    parameter int AXI_SW     = 3,
    parameter int AXI_BURSTW = 2,
    parameter int AXI_RRESPW = 2,
    parameter int ASI_RD     = 16,
    parameter int USR_RL     = 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [AXI_IW-1:0]     ARID,
    input  logic [AXI_AW-1:0]     ARADDR,
    input  logic [AXI_LW-1:0]     ARLEN,
    input  logic [AXI_SW-1:0]     ARSIZE,
    input  logic [AXI_BURSTW-1:0] ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [AXI_IW-1:0]     RID,
    output logic [AXI_DW-1:0]     RDATA,
    output logic [AXI_RRESPW-1:0] RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  usr_re,
    output logic [AXI_AW-1:0]     usr_raddr,
    output logic [AXI_SW-1:0]     usr_rsize,
    input  logic [AXI_DW-1:0]     usr_rdata
);

    localparam int RD_AW = $clog2(ASI_RD);
    localparam int CW    = RD_AW + 1;
    localparam int EW    = AXI_IW + AXI_DW + AXI_RRESPW + 1;

    localparam logic [AXI_SW-1:0]     MAX_SIZE    = AXI_SW'($clog2(AXI_DW / 8));
    localparam logic [AXI_RRESPW-1:0] RESP_OKAY   = '0;
    localparam logic [AXI_RRESPW-1:0] RESP_SLVERR = AXI_RRESPW'(2);

    localparam logic [AXI_BURSTW-1:0] BURST_FIXED = AXI_BURSTW'(0);
    localparam logic [AXI_BURSTW-1:0] BURST_INCR  = AXI_BURSTW'(1);
    localparam logic [AXI_BURSTW-1:0] BURST_WRAP  = AXI_BURSTW'(2);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]            state;
    logic                  ar_rdy;
    logic [AXI_IW-1:0]     id_q;
    logic [AXI_AW-1:0]     addr_q;
    logic [AXI_LW-1:0]     len_q;
    logic [AXI_SW-1:0]     size_q;
    logic [AXI_BURSTW-1:0] burst_q;
    logic                  err_q;
    logic [AXI_LW-1:0]     beat_q;
    logic [CW-1:0]         credit;

    logic                  ar_hs;
    logic                  ar_err;
    logic                  wrap_len_ok;
    logic                  issue;
    logic                  last_beat;

    logic [AXI_AW-1:0]     bytes;
    logic [AXI_AW-1:0]     incr_addr;
    logic [AXI_AW-1:0]     wrap_total;
    logic [AXI_AW-1:0]     wrap_lo;
    logic [AXI_AW-1:0]     next_addr;

    logic                  pipe_vld  [USR_RL];
    logic                  pipe_last [USR_RL];
    logic [AXI_RRESPW-1:0] pipe_resp [USR_RL];
    logic [AXI_IW-1:0]     pipe_id   [USR_RL];

    logic [EW-1:0]         fifo_mem [ASI_RD];
    logic [RD_AW:0]        wp;
    logic [RD_AW:0]        rp;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_wr;
    logic                  fifo_rd;
    logic [AXI_DW-1:0]     wr_data;
    logic [EW-1:0]         wr_entry;
    logic [EW-1:0]         head;

    assign ar_hs       = ARVALID && ar_rdy;
    assign wrap_len_ok = (ARLEN == AXI_LW'(1)) || (ARLEN == AXI_LW'(3)) ||
                         (ARLEN == AXI_LW'(7)) || (ARLEN == AXI_LW'(15));
    assign ar_err      = (ARBURST == AXI_BURSTW'(3)) ||
                         ((ARBURST == BURST_WRAP) && !wrap_len_ok) ||
                         (ARSIZE > MAX_SIZE);

    // Credit covers both the FIFO and the user-latency pipeline, so the FIFO can never overflow.
    assign issue     = (state == BURST) && (credit < CW'(ASI_RD));
    assign last_beat = (beat_q == len_q);

    assign bytes      = AXI_AW'(1) << size_q;
    assign incr_addr  = (addr_q & ~(bytes - AXI_AW'(1))) + bytes;
    assign wrap_total = (AXI_AW'(len_q) + AXI_AW'(1)) << size_q;
    assign wrap_lo    = addr_q & ~(wrap_total - AXI_AW'(1));

    always_comb begin
        next_addr = incr_addr;
        case (burst_q)
            BURST_FIXED: next_addr = addr_q;
            BURST_INCR:  next_addr = incr_addr;
            BURST_WRAP:  next_addr = (incr_addr == wrap_lo + wrap_total) ? wrap_lo : incr_addr;
            default:     next_addr = incr_addr;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state   <= IDLE;
            ar_rdy  <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
            beat_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        id_q    <= ARID;
                        addr_q  <= ARADDR;
                        len_q   <= ARLEN;
                        size_q  <= ARSIZE;
                        burst_q <= ARBURST;
                        err_q   <= ar_err;
                        beat_q  <= '0;
                        state   <= BURST;
                        ar_rdy  <= 1'b0;
                    end else begin
                        ar_rdy  <= 1'b1;
                    end
                end
                BURST: begin
                    if (issue) begin
                        beat_q <= beat_q + AXI_LW'(1);
                        addr_q <= next_addr;
                        if (last_beat) begin
                            state  <= IDLE;
                            ar_rdy <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    ar_rdy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            credit <= '0;
        end else begin
            case ({issue, fifo_rd})
                2'b10:   credit <= credit + CW'(1);
                2'b01:   credit <= credit - CW'(1);
                default: credit <= credit;
            endcase
        end
    end

    // The ID travels with each beat because a new burst may start before the old one drains.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < USR_RL; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_last[i] <= 1'b0;
                pipe_resp[i] <= '0;
                pipe_id[i]   <= '0;
            end
        end else begin
            pipe_vld[0]  <= issue;
            pipe_last[0] <= last_beat;
            pipe_resp[0] <= err_q ? RESP_SLVERR : RESP_OKAY;
            pipe_id[0]   <= id_q;
            for (int i = 1; i < USR_RL; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
                pipe_resp[i] <= pipe_resp[i-1];
                pipe_id[i]   <= pipe_id[i-1];
            end
        end
    end

    assign fifo_empty = (wp == rp);
    assign fifo_full  = (wp[RD_AW] != rp[RD_AW]) && (wp[RD_AW-1:0] == rp[RD_AW-1:0]);
    assign fifo_wr    = pipe_vld[USR_RL-1];
    assign fifo_rd    = !fifo_empty && RREADY;
    assign wr_data    = (pipe_resp[USR_RL-1] == RESP_SLVERR) ? {AXI_DW{1'b0}} : usr_rdata;
    assign wr_entry   = {pipe_id[USR_RL-1], wr_data, pipe_resp[USR_RL-1], pipe_last[USR_RL-1]};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (fifo_wr) wp <= wp + (RD_AW+1)'(1);
            if (fifo_rd) rp <= rp + (RD_AW+1)'(1);
        end
    end

    always_ff @(posedge ACLK) begin
        if (fifo_wr) fifo_mem[wp[RD_AW-1:0]] <= wr_entry;
    end

    assert property (@(posedge ACLK) disable iff (!ARESETn) fifo_wr |-> !fifo_full);

    // Outputs read as zero while the FIFO is empty, which also gives clean reset values.
    assign head = fifo_empty ? {EW{1'b0}} : fifo_mem[rp[RD_AW-1:0]];
    assign {RID, RDATA, RRESP, RLAST} = head;
    assign RVALID    = !fifo_empty;
    assign ARREADY   = ar_rdy;
    assign usr_re    = issue && !err_q;
    assign usr_raddr = addr_q;
    assign usr_rsize = size_q;

endmodule

// File: tb/tb_asi_r.sv
// Directed testbench for asi_r: a behavioural one-cycle-latency memory plus negedge monitors
// that log issued addresses and accepted R beats for per-scenario checks.
module tb_asi_r;

    logic         ACLK = 1'b0;
    logic         ARESETn;
    logic [7:0]   ARID;
    logic [39:0]  ARADDR;
    logic [7:0]   ARLEN;
    logic [2:0]   ARSIZE;
    logic [1:0]   ARBURST;
    logic         ARVALID;
    logic         ARREADY;
    logic [7:0]   RID;
    logic [127:0] RDATA;
    logic [1:0]   RRESP;
    logic         RLAST;
    logic         RVALID;
    logic         RREADY;
    logic         usr_re;
    logic [39:0]  usr_raddr;
    logic [2:0]   usr_rsize;
    logic [127:0] usr_rdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ar_cyc = 0;

    logic [39:0]  iss_q[$];
    int           iss_cyc_q[$];
    logic [7:0]   r_id_q[$];
    logic [127:0] r_data_q[$];
    logic [1:0]   r_resp_q[$];
    logic         r_last_q[$];
    int           r_cyc_q[$];

    asi_r dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .usr_re(usr_re), .usr_raddr(usr_raddr), .usr_rsize(usr_rsize),
        .usr_rdata(usr_rdata)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    function automatic logic [127:0] mem_fn(input logic [39:0] a);
        return {a[31:0], ~a[31:0], a[31:0] + 32'h1111_1111, a[31:0] ^ 32'hC0DE_0000};
    endfunction

    // Data is valid one cycle after the strobe; junk otherwise so zeroed error beats are visible.
    always @(posedge ACLK) begin
        if (usr_re) usr_rdata <= mem_fn(usr_raddr);
        else        usr_rdata <= {4{32'hDEAD_BEEF}};
    end

    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (ARVALID && ARREADY) ar_cyc = cyc;
            if (usr_re) begin
                iss_q.push_back(usr_raddr);
                iss_cyc_q.push_back(cyc);
            end
            if (RVALID && RREADY) begin
                r_id_q.push_back(RID);
                r_data_q.push_back(RDATA);
                r_resp_q.push_back(RRESP);
                r_last_q.push_back(RLAST);
                r_cyc_q.push_back(cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    task automatic clear_logs();
        iss_q.delete();
        iss_cyc_q.delete();
        r_id_q.delete();
        r_data_q.delete();
        r_resp_q.delete();
        r_last_q.delete();
        r_cyc_q.delete();
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [39:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        @(posedge ACLK); #1;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
        ARVALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (ARREADY) break;
        end
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (r_id_q.size() >= n) break;
            @(negedge ACLK);
        end
        repeat (4) @(negedge ACLK);
    endtask

    task automatic test_reset();
        ARESETn = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
        @(negedge ACLK);
        checks++; if (ARREADY !== 1'b0) begin errors++; $display("[TB] FAIL rst_arready: got %b want 0", ARREADY); end
        checks++; if (RVALID !== 1'b0) begin errors++; $display("[TB] FAIL rst_rvalid: got %b want 0", RVALID); end
        checks++; if (RLAST !== 1'b0) begin errors++; $display("[TB] FAIL rst_rlast: got %b want 0", RLAST); end
        checks++; if (RID !== 8'h00) begin errors++; $display("[TB] FAIL rst_rid: got %h want 00", RID); end
        checks++; if (RRESP !== 2'b00) begin errors++; $display("[TB] FAIL rst_rresp: got %b want 00", RRESP); end
        checks++; if (RDATA !== 128'h0) begin errors++; $display("[TB] FAIL rst_rdata: got %h want 0", RDATA); end
        checks++; if (usr_re !== 1'b0) begin errors++; $display("[TB] FAIL rst_usr_re: got %b want 0", usr_re); end
        checks++; if (usr_raddr !== 40'h0) begin errors++; $display("[TB] FAIL rst_usr_raddr: got %h want 0", usr_raddr); end
        checks++; if (usr_rsize !== 3'h0) begin errors++; $display("[TB] FAIL rst_usr_rsize: got %h want 0", usr_rsize); end
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        repeat (2) @(negedge ACLK);
        checks++; if (ARREADY !== 1'b1) begin errors++; $display("[TB] FAIL rst_arready_after: got %b want 1", ARREADY); end
    endtask

    task automatic test_incr();
        logic [39:0] exp_a[4] = '{40'h100, 40'h110, 40'h120, 40'h130};
        clear_logs();
        RREADY = 1'b1;
        send_ar(8'h5A, 40'h100, 8'd3, 3'd4, 2'd1);
        wait_beats(4, 50);
        checks++; if (iss_q.size() !== 4) begin errors++; $display("[TB] FAIL incr_issue_count: got %0d want 4", iss_q.size()); end
        checks++; if (r_id_q.size() !== 4) begin errors++; $display("[TB] FAIL incr_beat_count: got %0d want 4", r_id_q.size()); end
        for (int i = 0; i < 4 && i < iss_q.size(); i++) begin
            checks++; if (iss_q[i] !== exp_a[i]) begin errors++; $display("[TB] FAIL incr_addr[%0d]: got %h want %h", i, iss_q[i], exp_a[i]); end
            checks++; if (iss_cyc_q[i] !== ar_cyc + 1 + i) begin errors++; $display("[TB] FAIL incr_issue_cyc[%0d]: got %0d want %0d", i, iss_cyc_q[i], ar_cyc + 1 + i); end
        end
        for (int i = 0; i < 4 && i < r_id_q.size(); i++) begin
            checks++; if (r_id_q[i] !== 8'h5A) begin errors++; $display("[TB] FAIL incr_rid[%0d]: got %h want 5a", i, r_id_q[i]); end
            checks++; if (r_resp_q[i] !== 2'b00) begin errors++; $display("[TB] FAIL incr_rresp[%0d]: got %b want 00", i, r_resp_q[i]); end
            checks++; if (r_data_q[i] !== mem_fn(exp_a[i])) begin errors++; $display("[TB] FAIL incr_rdata[%0d]: got %h want %h", i, r_data_q[i], mem_fn(exp_a[i])); end
            checks++; if (r_last_q[i] !== (i == 3)) begin errors++; $display("[TB] FAIL incr_rlast[%0d]: got %b want %b", i, r_last_q[i], (i == 3)); end
        end
        if (r_cyc_q.size() > 0) begin
            checks++; if (r_cyc_q[0] !== ar_cyc + 3) begin errors++; $display("[TB] FAIL incr_first_rvalid: got cycle %0d want %0d", r_cyc_q[0], ar_cyc + 3); end
        end
    endtask

    task automatic test_wrap();
        logic [39:0] exp_a[4] = '{40'h138, 40'h120, 40'h128, 40'h130};
        clear_logs();
        send_ar(8'h3C, 40'h138, 8'd3, 3'd3, 2'd2);
        wait_beats(4, 50);
        checks++; if (iss_q.size() !== 4) begin errors++; $display("[TB] FAIL wrap_issue_count: got %0d want 4", iss_q.size()); end
        checks++; if (r_id_q.size() !== 4) begin errors++; $display("[TB] FAIL wrap_beat_count: got %0d want 4", r_id_q.size()); end
        for (int i = 0; i < 4 && i < iss_q.size(); i++) begin
            checks++; if (iss_q[i] !== exp_a[i]) begin errors++; $display("[TB] FAIL wrap_addr[%0d]: got %h want %h", i, iss_q[i], exp_a[i]); end
        end
        for (int i = 0; i < 4 && i < r_id_q.size(); i++) begin
            checks++; if (r_data_q[i] !== mem_fn(exp_a[i])) begin errors++; $display("[TB] FAIL wrap_rdata[%0d]: got %h want %h", i, r_data_q[i], mem_fn(exp_a[i])); end
            checks++; if (r_last_q[i] !== (i == 3)) begin errors++; $display("[TB] FAIL wrap_rlast[%0d]: got %b want %b", i, r_last_q[i], (i == 3)); end
        end
    endtask

    task automatic test_fixed_unaligned();
        logic [39:0] exp_u[3] = '{40'h103, 40'h104, 40'h108};
        clear_logs();
        send_ar(8'h44, 40'h44, 8'd7, 3'd2, 2'd0);
        wait_beats(8, 60);
        checks++; if (iss_q.size() !== 8) begin errors++; $display("[TB] FAIL fixed_issue_count: got %0d want 8", iss_q.size()); end
        checks++; if (r_id_q.size() !== 8) begin errors++; $display("[TB] FAIL fixed_beat_count: got %0d want 8", r_id_q.size()); end
        for (int i = 0; i < 8 && i < iss_q.size(); i++) begin
            checks++; if (iss_q[i] !== 40'h44) begin errors++; $display("[TB] FAIL fixed_addr[%0d]: got %h want 44", i, iss_q[i]); end
        end
        for (int i = 0; i < 8 && i < r_id_q.size(); i++) begin
            checks++; if (r_last_q[i] !== (i == 7)) begin errors++; $display("[TB] FAIL fixed_rlast[%0d]: got %b want %b", i, r_last_q[i], (i == 7)); end
        end
        clear_logs();
        send_ar(8'h45, 40'h103, 8'd2, 3'd2, 2'd1);
        wait_beats(3, 50);
        checks++; if (iss_q.size() !== 3) begin errors++; $display("[TB] FAIL unal_issue_count: got %0d want 3", iss_q.size()); end
        for (int i = 0; i < 3 && i < iss_q.size(); i++) begin
            checks++; if (iss_q[i] !== exp_u[i]) begin errors++; $display("[TB] FAIL unal_addr[%0d]: got %h want %h", i, iss_q[i], exp_u[i]); end
        end
        for (int i = 0; i < 3 && i < r_id_q.size(); i++) begin
            checks++; if (r_data_q[i] !== mem_fn(exp_u[i])) begin errors++; $display("[TB] FAIL unal_rdata[%0d]: got %h want %h", i, r_data_q[i], mem_fn(exp_u[i])); end
        end
    endtask

    task automatic test_len0();
        clear_logs();
        send_ar(8'h21, 40'h500, 8'd0, 3'd4, 2'd1);
        wait_beats(1, 30);
        checks++; if (iss_q.size() !== 1) begin errors++; $display("[TB] FAIL len0_issue_count: got %0d want 1", iss_q.size()); end
        checks++; if (r_id_q.size() !== 1) begin errors++; $display("[TB] FAIL len0_beat_count: got %0d want 1", r_id_q.size()); end
        if (r_id_q.size() > 0) begin
            checks++; if (r_last_q[0] !== 1'b1) begin errors++; $display("[TB] FAIL len0_rlast: got %b want 1", r_last_q[0]); end
            checks++; if (r_data_q[0] !== mem_fn(40'h500)) begin errors++; $display("[TB] FAIL len0_rdata: got %h want %h", r_data_q[0], mem_fn(40'h500)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] a;
        clear_logs();
        RREADY = 1'b0;
        send_ar(8'h77, 40'h1000, 8'd63, 3'd4, 2'd1);
        repeat (30) @(negedge ACLK);
        checks++; if (iss_q.size() !== 16) begin errors++; $display("[TB] FAIL bp_issue_stall: got %0d want 16", iss_q.size()); end
        checks++; if (RVALID !== 1'b1) begin errors++; $display("[TB] FAIL bp_rvalid_held: got %b want 1", RVALID); end
        checks++; if (RDATA !== mem_fn(40'h1000)) begin errors++; $display("[TB] FAIL bp_head_data: got %h want %h", RDATA, mem_fn(40'h1000)); end
        repeat (5) @(negedge ACLK);
        checks++; if (RDATA !== mem_fn(40'h1000)) begin errors++; $display("[TB] FAIL bp_head_stable: got %h want %h", RDATA, mem_fn(40'h1000)); end
        checks++; if (RID !== 8'h77) begin errors++; $display("[TB] FAIL bp_head_id: got %h want 77", RID); end
        checks++; if (RLAST !== 1'b0) begin errors++; $display("[TB] FAIL bp_head_last: got %b want 0", RLAST); end
        checks++; if (iss_q.size() !== 16) begin errors++; $display("[TB] FAIL bp_issue_still: got %0d want 16", iss_q.size()); end
        @(posedge ACLK); #1;
        RREADY = 1'b1;
        wait_beats(64, 300);
        checks++; if (r_id_q.size() !== 64) begin errors++; $display("[TB] FAIL bp_beat_count: got %0d want 64", r_id_q.size()); end
        checks++; if (iss_q.size() !== 64) begin errors++; $display("[TB] FAIL bp_issue_total: got %0d want 64", iss_q.size()); end
        for (int i = 0; i < 64 && i < r_id_q.size(); i++) begin
            a = 40'h1000 + 40'(i * 16);
            checks++; if (r_data_q[i] !== mem_fn(a)) begin errors++; $display("[TB] FAIL bp_rdata[%0d]: got %h want %h", i, r_data_q[i], mem_fn(a)); end
            checks++; if (r_last_q[i] !== (i == 63)) begin errors++; $display("[TB] FAIL bp_rlast[%0d]: got %b want %b", i, r_last_q[i], (i == 63)); end
        end
    endtask

    task automatic test_errors();
        clear_logs();
        send_ar(8'h11, 40'h200, 8'd1, 3'd4, 2'd3);
        wait_beats(2, 30);
        checks++; if (r_id_q.size() !== 2) begin errors++; $display("[TB] FAIL err_rsvd_beats: got %0d want 2", r_id_q.size()); end
        checks++; if (iss_q.size() !== 0) begin errors++; $display("[TB] FAIL err_rsvd_usr_re: got %0d issues want 0", iss_q.size()); end
        for (int i = 0; i < 2 && i < r_id_q.size(); i++) begin
            checks++; if (r_resp_q[i] !== 2'b10) begin errors++; $display("[TB] FAIL err_rsvd_rresp[%0d]: got %b want 10", i, r_resp_q[i]); end
            checks++; if (r_data_q[i] !== 128'h0) begin errors++; $display("[TB] FAIL err_rsvd_rdata[%0d]: got %h want 0", i, r_data_q[i]); end
            checks++; if (r_last_q[i] !== (i == 1)) begin errors++; $display("[TB] FAIL err_rsvd_rlast[%0d]: got %b want %b", i, r_last_q[i], (i == 1)); end
            checks++; if (r_id_q[i] !== 8'h11) begin errors++; $display("[TB] FAIL err_rsvd_rid[%0d]: got %h want 11", i, r_id_q[i]); end
        end
        clear_logs();
        send_ar(8'h12, 40'h200, 8'd2, 3'd4, 2'd2);
        wait_beats(3, 30);
        checks++; if (r_id_q.size() !== 3) begin errors++; $display("[TB] FAIL err_wrap_beats: got %0d want 3", r_id_q.size()); end
        checks++; if (iss_q.size() !== 0) begin errors++; $display("[TB] FAIL err_wrap_usr_re: got %0d issues want 0", iss_q.size()); end
        for (int i = 0; i < 3 && i < r_id_q.size(); i++) begin
            checks++; if (r_resp_q[i] !== 2'b10) begin errors++; $display("[TB] FAIL err_wrap_rresp[%0d]: got %b want 10", i, r_resp_q[i]); end
            checks++; if (r_last_q[i] !== (i == 2)) begin errors++; $display("[TB] FAIL err_wrap_rlast[%0d]: got %b want %b", i, r_last_q[i], (i == 2)); end
        end
        clear_logs();
        send_ar(8'h13, 40'h300, 8'd0, 3'd5, 2'd1);
        wait_beats(1, 30);
        checks++; if (r_id_q.size() !== 1) begin errors++; $display("[TB] FAIL err_size_beats: got %0d want 1", r_id_q.size()); end
        checks++; if (iss_q.size() !== 0) begin errors++; $display("[TB] FAIL err_size_usr_re: got %0d issues want 0", iss_q.size()); end
        if (r_id_q.size() > 0) begin
            checks++; if (r_resp_q[0] !== 2'b10) begin errors++; $display("[TB] FAIL err_size_rresp: got %b want 10", r_resp_q[0]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        clear_logs();
        RREADY = 1'b0;
        send_ar(8'h66, 40'h300, 8'd7, 3'd4, 2'd1);
        for (int i = 0; i < 20; i++) begin
            if (iss_q.size() >= 2) break;
            @(negedge ACLK);
        end
        repeat (2) @(negedge ACLK);
        checks++; if (RVALID !== 1'b1) begin errors++; $display("[TB] FAIL mid_rvalid_before: got %b want 1", RVALID); end
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        @(negedge ACLK);
        checks++; if (RVALID !== 1'b0) begin errors++; $display("[TB] FAIL mid_rvalid_reset: got %b want 0", RVALID); end
        checks++; if (usr_re !== 1'b0) begin errors++; $display("[TB] FAIL mid_usr_re_reset: got %b want 0", usr_re); end
        checks++; if (ARREADY !== 1'b0) begin errors++; $display("[TB] FAIL mid_arready_reset: got %b want 0", ARREADY); end
        repeat (2) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        clear_logs();
        RREADY = 1'b1;
        send_ar(8'h33, 40'h400, 8'd1, 3'd4, 2'd1);
        wait_beats(2, 30);
        repeat (5) @(negedge ACLK);
        checks++; if (r_id_q.size() !== 2) begin errors++; $display("[TB] FAIL mid_post_beats: got %0d want 2", r_id_q.size()); end
        for (int i = 0; i < 2 && i < r_id_q.size(); i++) begin
            checks++; if (r_id_q[i] !== 8'h33) begin errors++; $display("[TB] FAIL mid_post_rid[%0d]: got %h want 33", i, r_id_q[i]); end
            checks++; if (r_data_q[i] !== mem_fn(40'h400 + 40'(i * 16))) begin errors++; $display("[TB] FAIL mid_post_rdata[%0d]: got %h want %h", i, r_data_q[i], mem_fn(40'h400 + 40'(i * 16))); end
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed_unaligned();
        test_len0();
        test_back_to_back();
        test_errors();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
